// File: rtl/branch_predictor.sv
// branch_predictor
// Fetch-stage branch predictor. It is a direct-mapped branch target buffer
// with a 2-bit saturating counter in each entry.
//
// Ports:
//   clk, rst         clock and synchronous active-high reset
//   pc_f, inst_f     fetch PC and the instruction fetched there
//   pred_taken       prediction: redirect fetch to pred_target
//   pred_target      predicted next PC (entry target, or pc_f+4)
//   ex_valid         EX holds a real instruction
//   ex_pc, ex_inst   PC and instruction in EX
//   ex_jump          resolved taken decision from the branch comparator
//   ex_target        resolved target address
//   ex_pred_taken    pred_taken carried down the pipe with this instruction
//   ex_pred_target   pred_target carried down the pipe with this instruction
//   mispredict       flush IF/ID and load redirect_pc at this edge
//   redirect_pc      correct next PC for the EX instruction
//   br_cnt           resolved control-flow instructions (saturating)
//   mis_cnt          mispredicts (saturating)
module branch_predictor #(
    parameter int ENTRIES = 16,
    parameter int INDEX_W = 4,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      pc_f,
    input  logic [31:0]      inst_f,
    output logic             pred_taken,
    output logic [31:0]      pred_target,
    input  logic             ex_valid,
    input  logic [31:0]      ex_pc,
    input  logic [31:0]      ex_inst,
    input  logic             ex_jump,
    input  logic [31:0]      ex_target,
    input  logic             ex_pred_taken,
    input  logic [31:0]      ex_pred_target,
    output logic             mispredict,
    output logic [31:0]      redirect_pc,
    output logic [CNT_W-1:0] br_cnt,
    output logic [CNT_W-1:0] mis_cnt
);

    localparam int TAG_W = 30 - INDEX_W;
    localparam logic [4:0] OP_B    = 5'b11000;
    localparam logic [4:0] OP_JAL  = 5'b11011;
    localparam logic [4:0] OP_JALR = 5'b11001;
    localparam logic [CNT_W-1:0] CNT_ONE = 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [ENTRIES-1:0] valid_q;
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [31:0]        target_q [ENTRIES];
    logic [1:0]         ctr_q    [ENTRIES];

    // Fetch-side decode and table read
    logic               f_is_b, f_is_j, f_hit;
    logic [INDEX_W-1:0] f_idx;
    logic [TAG_W-1:0]   f_tag;

    assign f_is_b = (inst_f[6:2] == OP_B);
    assign f_is_j = (inst_f[6:2] == OP_JAL) || (inst_f[6:2] == OP_JALR);
    assign f_idx  = pc_f[INDEX_W+1:2];
    assign f_tag  = pc_f[31:INDEX_W+2];
    assign f_hit  = valid_q[f_idx] && (tag_q[f_idx] == f_tag);

    // The lookup reads the registered table, so an update made at this edge
    // is not seen until the next cycle (no bypass). Unconditional jumps
    // ignore the counter. A hit on a non-control-flow word never redirects.
    always_comb begin
        pred_taken = 1'b0;
        if (f_is_b) begin
            pred_taken = f_hit && ctr_q[f_idx][1];
        end else if (f_is_j) begin
            pred_taken = f_hit;
        end
        pred_target = pred_taken ? target_q[f_idx] : pc_f + 32'd4;
    end

    // EX-side decode and resolution
    logic               ex_is_b, ex_is_j, ex_cf, eff_jump, upd_en, ex_hit;
    logic [INDEX_W-1:0] ex_idx;
    logic [TAG_W-1:0]   ex_tag;

    assign ex_is_b  = (ex_inst[6:2] == OP_B);
    assign ex_is_j  = (ex_inst[6:2] == OP_JAL) || (ex_inst[6:2] == OP_JALR);
    assign ex_cf    = ex_is_b || ex_is_j;
    // A jump flag on a non-control-flow instruction is meaningless; drop it.
    assign eff_jump = ex_jump && ex_cf;
    assign upd_en   = ex_valid && ex_cf && !rst;
    assign ex_idx   = ex_pc[INDEX_W+1:2];
    assign ex_tag   = ex_pc[31:INDEX_W+2];
    assign ex_hit   = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);

    // A stale aliased prediction on a non-control-flow instruction also
    // counts as a mispredict, because fetch was already sent the wrong way.
    assign mispredict  = !rst && ex_valid &&
                         ((eff_jump != ex_pred_taken) ||
                          (eff_jump && (ex_target != ex_pred_target)));
    assign redirect_pc = eff_jump ? ex_target : ex_pc + 32'd4;

    // Training decision for the entry selected by the EX PC
    logic       alloc, wr_tgt, wr_ctr;
    logic [1:0] cur_ctr, new_ctr;

    assign cur_ctr = ctr_q[ex_idx];

    always_comb begin
        alloc   = 1'b0;
        wr_tgt  = 1'b0;
        wr_ctr  = 1'b0;
        new_ctr = cur_ctr;
        if (upd_en) begin
            if (!ex_hit) begin
                // Only taken control flow earns an entry; it evicts whatever
                // was there.
                if (eff_jump) begin
                    alloc   = 1'b1;
                    wr_tgt  = 1'b1;
                    wr_ctr  = 1'b1;
                    new_ctr = ex_is_b ? 2'b10 : 2'b11;
                end
            end else if (ex_is_b) begin
                wr_ctr = 1'b1;
                if (eff_jump) begin
                    wr_tgt  = 1'b1;
                    new_ctr = (cur_ctr == 2'b11) ? 2'b11 : cur_ctr + 2'd1;
                end else begin
                    new_ctr = (cur_ctr == 2'b00) ? 2'b00 : cur_ctr - 2'd1;
                end
            end else begin
                wr_ctr  = 1'b1;
                wr_tgt  = 1'b1;
                new_ctr = 2'b11;
            end
        end
    end

    // Valid bits and counters are the only table state that gets reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                ctr_q[i] <= 2'b01;
            end
        end else begin
            if (alloc) begin
                valid_q[ex_idx] <= 1'b1;
            end
            if (wr_ctr) begin
                ctr_q[ex_idx] <= new_ctr;
            end
        end
    end

    // Tags and targets are never reset; valid_q guards them. upd_en already
    // excludes reset cycles.
    always_ff @(posedge clk) begin
        if (alloc) begin
            tag_q[ex_idx] <= ex_tag;
        end
        if (wr_tgt) begin
            target_q[ex_idx] <= ex_target;
        end
    end

    // Statistics counters stick at all-ones instead of wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            br_cnt  <= '0;
            mis_cnt <= '0;
        end else begin
            if (ex_valid && ex_cf && (br_cnt != CNT_MAX)) begin
                br_cnt <= br_cnt + CNT_ONE;
            end
            if (mispredict && (mis_cnt != CNT_MAX)) begin
                mis_cnt <= mis_cnt + CNT_ONE;
            end
        end
    end

    // Only the opcode class bits of the instruction words are needed.
    logic unused_inst_bits;
    assign unused_inst_bits = ^{inst_f[31:7], inst_f[1:0], ex_inst[31:7], ex_inst[1:0]};

endmodule
